pmem_arbiter: RTL

- Shares the single physical-memory line port between the I-cache (read-only) and the D-cache (read/write) on cache misses.
- Sits below both caches and above the cacheline adaptor, behind IF_stall and MA_stall.
- Fixed D-cache priority, plus a bounded-starvation rule for the I-cache.
- Transactions are non-preemptive: a granted line transfer runs to mem_resp.

---
 rtl/pmem_arbiter_pkg.sv | 13 +
 rtl/pmem_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/pmem_arbiter_pkg.sv
// rtl/pmem_arbiter_pkg.sv - shared types for the physical-memory line-port arbiter
package pmem_arb_types;

    typedef enum logic [1:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE
    } arb_state_t;

    localparam int LINE_W_DEFAULT = 256;

endpackage

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - I-cache/D-cache arbiter for the single cacheline adaptor port
module pmem_arbiter
    import pmem_arb_types::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int LINE_W       = LINE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state;
    logic [SW-1:0] streak;
    logic [SW-1:0] d_streak_next;
    logic          d_req;
    logic          i_win;

    assign d_req = d_pmem_read | d_pmem_write;
    // The I-cache wins either uncontested or once D has used up its streak allowance.
    assign i_win = i_pmem_read && (!d_req || (streak == STREAK_MAX));

    // A D grant only counts toward the streak while the I-cache is actually waiting.
    assign d_streak_next = !i_pmem_read          ? '0 :
                           (streak == STREAK_MAX) ? streak :
                                                    streak + 1'b1;

    assign i_pmem_resp  = !rst && (state == I_READ) && mem_resp;
    assign d_pmem_resp  = !rst && ((state == D_READ) || (state == D_WRITE)) && mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_win) begin
                        state       <= I_READ;
                        mem_read    <= 1'b1;
                        mem_address <= i_pmem_address;
                        streak      <= '0;
                    end else if (d_pmem_write) begin
                        state       <= D_WRITE;
                        mem_write   <= 1'b1;
                        mem_address <= d_pmem_address;
                        mem_wdata   <= d_pmem_wdata;
                        streak      <= d_streak_next;
                    end else if (d_pmem_read) begin
                        state       <= D_READ;
                        mem_read    <= 1'b1;
                        mem_address <= d_pmem_address;
                        streak      <= d_streak_next;
                    end
                end
                default: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Simultaneous D read and write is a D-cache bug; it is resolved as a writeback.
    assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));

endmodule
